// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the dual-lane memory-access stage.
// Memory-op and FSM encodings plus the per-lane write-back helpers.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_LW   = 2'b01,
    MEM_SW   = 2'b10
  } mem_op_e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_SECOND = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] st;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        rw;
  } lane_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } wb_t;

  // Encoding 2'b11 is deliberately treated as "no memory op".
  function automatic logic is_mem(input logic [1:0] op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

  function automatic logic [31:0] wb_sel(input logic [1:0] op, input logic [31:0] rdata,
                                         input logic [31:0] alu);
    return (op == MEM_LW) ? rdata : alu;
  endfunction

  function automatic logic lane_we(input lane_t l, input logic mis);
    return l.rw && (l.op != MEM_SW) && !((l.op == MEM_LW) && mis);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-ported data-memory bus between mem_stage (master) and the memory (slave).
interface mem_stage_if #(parameter int DM_ADDR_W = 10);
  logic [DM_ADDR_W-1:0] dm_addr;
  logic [31:0]          dm_wdata;
  logic                 dm_we;
  logic [31:0]          dm_rdata;

  modport master (output dm_addr, output dm_wdata, output dm_we, input dm_rdata);
  modport slave  (input dm_addr, input dm_wdata, input dm_we, output dm_rdata);
endinterface

// File: rtl/mem_stage.sv
// Dual-lane memory stage: serialises two memory ops over one single-ported DM.
// Build with ALIGN_CHECK_EN defined to add misalignment detection outputs.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ALU_out1,
  input  logic [31:0] ALU_out2,
  input  logic [31:0] st_data1,
  input  logic [31:0] st_data2,
  input  logic [1:0]  mem_op1,
  input  logic [1:0]  mem_op2,
  input  logic [4:0]  rd1,
  input  logic [4:0]  rd2,
  input  logic        regwrite1,
  input  logic        regwrite2,
  input  logic        clear_lane2,
  mem_stage_if.master dm,
  output logic        mem_stall,
  output logic [31:0] wb_data1,
  output logic [31:0] wb_data2,
  output logic [4:0]  wb_rd1,
  output logic [4:0]  wb_rd2,
  output logic        wb_we1,
  output logic        wb_we2
`ifdef ALIGN_CHECK_EN
  ,
  output logic        misalign1,
  output logic        misalign2
`endif
);

  lane_t       lane1_q, lane1_d, lane2_q, lane2_d, srv;
  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  wb_t         wb1_q, wb1_d, wb2_q, wb2_d;
  logic        both_mem, serve2, mis1, mis2, srv_mis;

`ifdef ALIGN_CHECK_EN
  logic misalign1_q, misalign1_d, misalign2_q, misalign2_d;
  assign mis1 = is_mem(lane1_q.op) && (lane1_q.alu[1:0] != 2'b00);
  assign mis2 = is_mem(lane2_q.op) && (lane2_q.alu[1:0] != 2'b00);
  assign misalign1 = misalign1_q;
  assign misalign2 = misalign2_q;
`else
  assign mis1 = 1'b0;
  assign mis2 = 1'b0;
`endif

  assign both_mem  = is_mem(lane1_q.op) && is_mem(lane2_q.op);
  assign mem_stall = (state_q == S_RUN) && both_mem;

  // Lane 2 owns the port in the second slot, or whenever lane 1 has no memory op.
  assign serve2  = (state_q == S_SECOND) || !is_mem(lane1_q.op);
  assign srv     = serve2 ? lane2_q : lane1_q;
  assign srv_mis = serve2 ? mis2 : mis1;

  assign dm.dm_addr  = is_mem(srv.op) ? srv.alu[DM_ADDR_W+1:2] : '0;
  assign dm.dm_wdata = (srv.op == MEM_SW) ? srv.st : '0;
  assign dm.dm_we    = (srv.op == MEM_SW) && !srv_mis && !RST;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    lane1_d = lane1_q;
    lane2_d = lane2_q;
    state_d = state_q;
    hold_d  = hold_q;
    wb1_d   = wb1_q;
    wb2_d   = wb2_q;
`ifdef ALIGN_CHECK_EN
    misalign1_d = misalign1_q;
    misalign2_d = misalign2_q;
`endif

    if (!mem_stall) begin
      lane1_d = '{alu: ALU_out1, st: st_data1, op: mem_op1, rd: rd1, rw: regwrite1};
      lane2_d = '{alu: ALU_out2, st: st_data2, op: mem_op2, rd: rd2, rw: regwrite2};
      if (clear_lane2) begin
        lane2_d.op = MEM_NONE;
        lane2_d.rw = 1'b0;
      end
    end

    case (state_q)
      S_RUN: begin
        if (both_mem) begin
          hold_d  = dm.dm_rdata;
          state_d = S_SECOND;
        end else begin
          wb1_d = '{data: wb_sel(lane1_q.op, dm.dm_rdata, lane1_q.alu), rd: lane1_q.rd,
                    we: lane_we(lane1_q, mis1)};
          wb2_d = '{data: wb_sel(lane2_q.op, dm.dm_rdata, lane2_q.alu), rd: lane2_q.rd,
                    we: lane_we(lane2_q, mis2)};
`ifdef ALIGN_CHECK_EN
          misalign1_d = mis1;
          misalign2_d = mis2;
`endif
        end
      end
      S_SECOND: begin
        wb1_d = '{data: wb_sel(lane1_q.op, hold_q, lane1_q.alu), rd: lane1_q.rd,
                  we: lane_we(lane1_q, mis1)};
        wb2_d = '{data: wb_sel(lane2_q.op, dm.dm_rdata, lane2_q.alu), rd: lane2_q.rd,
                  we: lane_we(lane2_q, mis2)};
`ifdef ALIGN_CHECK_EN
        misalign1_d = mis1;
        misalign2_d = mis2;
`endif
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lane1_q <= '0;
      lane2_q <= '0;
      state_q <= S_RUN;
      hold_q  <= '0;
      wb1_q   <= '0;
      wb2_q   <= '0;
`ifdef ALIGN_CHECK_EN
      misalign1_q <= 1'b0;
      misalign2_q <= 1'b0;
`endif
    end else begin
      lane1_q <= lane1_d;
      lane2_q <= lane2_d;
      state_q <= state_d;
      hold_q  <= hold_d;
      wb1_q   <= wb1_d;
      wb2_q   <= wb2_d;
`ifdef ALIGN_CHECK_EN
      misalign1_q <= misalign1_d;
      misalign2_q <= misalign2_d;
`endif
    end
  end

  assign wb_data1 = wb1_q.data;
  assign wb_data2 = wb2_q.data;
  assign wb_rd1   = wb1_q.rd;
  assign wb_rd2   = wb2_q.rd;
  assign wb_we1   = wb1_q.we;
  assign wb_we2   = wb2_q.we;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage with a behavioural data memory.
// Define ALIGN_CHECK_EN for both bench and RTL to exercise the alignment checks.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] ALU_out1, ALU_out2, st_data1, st_data2;
  logic [1:0]  mem_op1, mem_op2;
  logic [4:0]  rd1, rd2;
  logic        regwrite1, regwrite2, clear_lane2;
  logic        mem_stall, wb_we1, wb_we2;
  logic [31:0] wb_data1, wb_data2;
  logic [4:0]  wb_rd1, wb_rd2;
`ifdef ALIGN_CHECK_EN
  logic        misalign1, misalign2;
`endif

  mem_stage_if #(.DM_ADDR_W(10)) dm_if ();

  mem_stage #(.DM_ADDR_W(10)) dut (
    .CLK(CLK), .RST(RST),
    .ALU_out1(ALU_out1), .ALU_out2(ALU_out2),
    .st_data1(st_data1), .st_data2(st_data2),
    .mem_op1(mem_op1), .mem_op2(mem_op2),
    .rd1(rd1), .rd2(rd2),
    .regwrite1(regwrite1), .regwrite2(regwrite2),
    .clear_lane2(clear_lane2),
    .dm(dm_if.master),
    .mem_stall(mem_stall),
    .wb_data1(wb_data1), .wb_data2(wb_data2),
    .wb_rd1(wb_rd1), .wb_rd2(wb_rd2),
    .wb_we1(wb_we1), .wb_we2(wb_we2)
`ifdef ALIGN_CHECK_EN
    , .misalign1(misalign1), .misalign2(misalign2)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural single-ported memory with a bench-side preload port.
  logic [31:0] dm_mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign dm_if.dm_rdata = dm_mem[dm_if.dm_addr];

  always @(posedge CLK) begin
    if (pre_we) dm_mem[pre_addr] <= pre_data;
    else if (dm_if.dm_we) dm_mem[dm_if.dm_addr] <= dm_if.dm_wdata;
  end

  typedef struct {
    logic [31:0] d1, d2;
    logic [4:0]  r1, r2;
    logic        we1, we2;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(posedge CLK); #1;
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge CLK); #1;
    pre_we = 1'b0;
  endtask

  task automatic go_idle();
    ALU_out1 = '0; ALU_out2 = '0; st_data1 = '0; st_data2 = '0;
    mem_op1 = MEM_NONE; mem_op2 = MEM_NONE; rd1 = '0; rd2 = '0;
    regwrite1 = 1'b0; regwrite2 = 1'b0; clear_lane2 = 1'b0;
  endtask

  // Drives one bundle for a single capture edge and records its expected write-back.
  task automatic issue(input logic [31:0] a1, input logic [31:0] s1, input logic [1:0] o1,
                       input logic [4:0] r1, input logic w1,
                       input logic [31:0] a2, input logic [31:0] s2, input logic [1:0] o2,
                       input logic [4:0] r2, input logic w2, input logic clr, input exp_t e);
    @(posedge CLK); #1;
    ALU_out1 = a1; st_data1 = s1; mem_op1 = o1; rd1 = r1; regwrite1 = w1;
    ALU_out2 = a2; st_data2 = s2; mem_op2 = o2; rd2 = r2; regwrite2 = w2;
    clear_lane2 = clr;
    exp_q.push_back(e);
  endtask

  task automatic compare_wb(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    check({tag, ".wb_data1"}, wb_data1, e.d1);
    check({tag, ".wb_data2"}, wb_data2, e.d2);
    check({tag, ".wb_rd1"}, {27'd0, wb_rd1}, {27'd0, e.r1});
    check({tag, ".wb_rd2"}, {27'd0, wb_rd2}, {27'd0, e.r2});
    check({tag, ".wb_we1"}, {31'd0, wb_we1}, {31'd0, e.we1});
    check({tag, ".wb_we2"}, {31'd0, wb_we2}, {31'd0, e.we2});
  endtask

  // Runs the captured bundle through the stage, counting stall and write cycles.
  task automatic run_bundle(input string tag, input int exp_stalls, input int exp_writes);
    int stalls, writes;
    @(posedge CLK); #1;
    go_idle();
    stalls = 0;
    writes = 0;
    for (int c = 0; c < 1 + exp_stalls; c++) begin
      @(negedge CLK);
      stalls += int'(mem_stall);
      writes += int'(dm_if.dm_we);
      @(posedge CLK);
    end
    @(negedge CLK);
    compare_wb(tag);
    check({tag, ".stall_cycles"}, stalls, exp_stalls);
    check({tag, ".dm_writes"}, writes, exp_writes);
  endtask

  initial begin
    go_idle();
    preload(10'h000, 32'h0);
    preload(10'h002, 32'h0000_1234);
    preload(10'h003, 32'h0000_5678);
    preload(10'h009, 32'h9999_9999);
    preload(10'h015, 32'hAAAA_5555);
    @(posedge CLK); #1;
    RST = 1'b0;
    issue(32'h0000_00AA, 32'h0, MEM_NONE, 5'd1, 1'b1, 32'h0000_00BB, 32'h0, MEM_NONE, 5'd2,
          1'b1, 1'b0, '{32'hAA, 32'hBB, 5'd1, 5'd2, 1'b1, 1'b1});
    run_bundle("warmup", 0, 0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst.wb_data1", wb_data1, 32'h0);
    check("rst.wb_data2", wb_data2, 32'h0);
    check("rst.wb_rd1", {27'd0, wb_rd1}, 32'h0);
    check("rst.wb_we1", {31'd0, wb_we1}, 32'h0);
    check("rst.wb_we2", {31'd0, wb_we2}, 32'h0);
    check("rst.mem_stall", {31'd0, mem_stall}, 32'h0);
    check("rst.dm_we", {31'd0, dm_if.dm_we}, 32'h0);

    issue(32'h10, 32'h0, MEM_NONE, 5'd3, 1'b1, 32'h77, 32'h0, MEM_NONE, 5'd7, 1'b1, 1'b0,
          '{32'h10, 32'h77, 5'd3, 5'd7, 1'b1, 1'b1});
    run_bundle("alu_only", 0, 0);

    issue(32'h40, 32'hDEAD_BEEF, MEM_SW, 5'd1, 1'b1, 32'h40, 32'h0, MEM_LW, 5'd5, 1'b1, 1'b0,
          '{32'h40, 32'hDEAD_BEEF, 5'd1, 5'd5, 1'b0, 1'b1});
    run_bundle("sw_then_lw", 1, 1);
    check("sw_then_lw.dm_word10", dm_mem[10'h010], 32'hDEAD_BEEF);

    issue(32'h8, 32'h0, MEM_LW, 5'd1, 1'b1, 32'hC, 32'h0, MEM_LW, 5'd2, 1'b1, 1'b0,
          '{32'h1234, 32'h5678, 5'd1, 5'd2, 1'b1, 1'b1});
    run_bundle("lw_lw", 1, 0);

    issue(32'h20, 32'hA5A5_A5A5, MEM_SW, 5'd6, 1'b0, 32'h24, 32'h5A5A_5A5A, MEM_SW, 5'd8,
          1'b1, 1'b1, '{32'h20, 32'h24, 5'd6, 5'd8, 1'b0, 1'b0});
    run_bundle("clear_lane2", 0, 1);
    check("clear_lane2.dm_word8", dm_mem[10'h008], 32'hA5A5_A5A5);
    check("clear_lane2.dm_word9", dm_mem[10'h009], 32'h9999_9999);

    issue(32'h40, 32'h0, MEM_LW, 5'd4, 1'b1, 32'h40, 32'hCAFE_F00D, MEM_SW, 5'd9, 1'b1, 1'b0,
          '{32'hDEAD_BEEF, 32'h40, 5'd4, 5'd9, 1'b1, 1'b0});
    run_bundle("lw_then_sw", 1, 1);
    check("lw_then_sw.dm_word10", dm_mem[10'h010], 32'hCAFE_F00D);

    issue(32'h99, 32'h0, MEM_NONE, 5'd10, 1'b1, 32'hC, 32'h0, MEM_LW, 5'd11, 1'b1, 1'b0,
          '{32'h99, 32'h5678, 5'd10, 5'd11, 1'b1, 1'b1});
    run_bundle("lane2_lw", 0, 0);

    issue(32'h30, 32'h0, 2'b11, 5'd12, 1'b1, 32'h8, 32'h0, MEM_LW, 5'd13, 1'b1, 1'b0,
          '{32'h30, 32'h1234, 5'd12, 5'd13, 1'b1, 1'b1});
    run_bundle("op11_as_none", 0, 0);

    // Reset lands while the second slot is pending.
    issue(32'h50, 32'h1111_1111, MEM_SW, 5'd1, 1'b1, 32'h54, 32'h2222_2222, MEM_SW, 5'd2, 1'b1,
          1'b0, '{32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0});
    @(posedge CLK); #1;
    go_idle();
    @(negedge CLK);
    check("rst_second.stall", {31'd0, mem_stall}, 32'h1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_second.dm_we", {31'd0, dm_if.dm_we}, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    compare_wb("rst_second");
    check("rst_second.stall_after", {31'd0, mem_stall}, 32'h0);
    check("rst_second.dm_word14", dm_mem[10'h014], 32'h1111_1111);
    check("rst_second.dm_word15", dm_mem[10'h015], 32'hAAAA_5555);

    issue(32'h5, 32'h0, MEM_NONE, 5'd1, 1'b1, 32'h50, 32'h0, MEM_LW, 5'd2, 1'b1, 1'b0,
          '{32'h5, 32'h1111_1111, 5'd1, 5'd2, 1'b1, 1'b1});
    run_bundle("after_rst", 0, 0);

`ifdef ALIGN_CHECK_EN
    issue(32'h41, 32'hBAD0_BAD0, MEM_SW, 5'd3, 1'b1, 32'h0, 32'h0, MEM_NONE, 5'd0, 1'b0, 1'b0,
          '{32'h41, 32'h0, 5'd3, 5'd0, 1'b0, 1'b0});
    run_bundle("misalign_sw", 0, 0);
    check("misalign_sw.misalign1", {31'd0, misalign1}, 32'h1);
    check("misalign_sw.misalign2", {31'd0, misalign2}, 32'h0);
    check("misalign_sw.dm_word10", dm_mem[10'h010], 32'hCAFE_F00D);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Dual-lane memory-access stage directly downstream of the execute stage.
- Consumes both ALU results plus store data and memory-op control, and drives a single-ported data memory.
- Registers write-back results for both lanes, which also serve as the DM->ALU bypass source.
- When both lanes access memory in the same bundle, the accesses are serialised over two cycles with a stall to upstream.

Parameters:
DM_ADDR_W, 10, word-index width of data memory; word index = addr[DM_ADDR_W+1:2]

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  synchronous active-high reset
ALU_out1  in  32  lane-1 ALU result (load/store address or arithmetic result)
ALU_out2  in  32  lane-2 ALU result
st_data1  in  32  lane-1 store data
st_data2  in  32  lane-2 store data
mem_op1  in  2  lane-1 memory op: 00 none, 01 load word, 10 store word, 11 treated as none
mem_op2  in  2  lane-2 memory op, same encoding
rd1  in  5  lane-1 destination register
rd2  in  5  lane-2 destination register
regwrite1  in  1  lane-1 writes the register file
regwrite2  in  1  lane-2 writes the register file
clear_lane2  in  1  execute-stage clear_pipeline2; kills lane 2 of the bundle being captured
dm_addr  out  DM_ADDR_W  data-memory word index
dm_wdata  out  32  data-memory write data
dm_we  out  1  data-memory write enable
dm_rdata  in  32  data-memory read data; combinational read
mem_stall  out  1  upstream must hold its outputs
wb_data1  out  32  lane-1 write-back value; also bypass value
wb_data2  out  32  lane-2 write-back value; also bypass value
wb_rd1  out  5  lane-1 write-back destination
wb_rd2  out  5  lane-2 write-back destination
wb_we1  out  1  lane-1 register-file write enable
wb_we2  out  1  lane-2 register-file write enable

Behaviour:
- Input capture: input registers load on posedge when mem_stall=0 and are held when mem_stall=1.
- Lane-2 kill: if clear_lane2=1 at capture, lane 2 is captured with mem_op=00 and regwrite=0.
- FSM states: S_RUN, S_SECOND.
- S_RUN:
  - DM serves lane 1 if it is a memory op, else lane 2.
  - If both captured lanes are memory ops: assert mem_stall=1 combinationally and serve lane 1. A lane-1 load latches dm_rdata into a hold register, a lane-1 store writes DM. Go to S_SECOND at the next edge.
  - Otherwise: mem_stall=0 and outputs register at the next edge.
- S_SECOND:
  - DM serves lane 2 and mem_stall=0.
  - At the next edge, wb_* registers both lanes (lane 1 from the hold register when it is a load), then go to S_RUN.
- Write-back data selection per lane: load gives dm_rdata (or hold); store or none gives the ALU result.
- Write-back enable: wb_we = regwrite AND op != store.
- Latency:
  - Single/no memory op: 1 cycle from capture edge to wb_* valid.
  - Dual memory op: 2 cycles, with upstream frozen for 1 cycle.
- Same-address ordering: lane-1 store followed by lane-2 load to the same word returns the new data, because serialisation guarantees it. Lane-1 load followed by lane-2 store returns the old data.
- dm_we is high only in the cycle a store lane is served. dm_addr and dm_wdata are don't-care when no lane is served but are driven to 0.
- Reset: all wb_* = 0, mem_stall = 0, dm_we = 0, state = S_RUN, input and hold registers = 0.
- RST in S_SECOND:
  - The pending lane-2 access is abandoned and dm_we is forced 0 in that cycle.
  - A lane-1 store already performed is not undone.

Optional Feature:
ALIGN_CHECK_EN
- Defined:
  - Adds outputs misalign1 and misalign2 (1 bit each, registered with wb_*). Each is set when its lane is a memory op with addr[1:0] != 0.
  - A misaligned store has dm_we suppressed. A misaligned load has wb_we forced to 0.
  - A misaligned lane still consumes its serialisation slot.
- Undefined:
  - Address bits [1:0] are ignored and the ports are absent.

Decomposition:
- Shared package/macro file:
  - mem_op encodings MEM_NONE, MEM_LW, MEM_SW.
  - FSM state encodings S_RUN, S_SECOND.
- No sub-module: the lane mux and FSM are small.
- A per-lane wb-select helper is inlined in both lanes.

Test Plan:
- Lane1 add result 0x0000_0010 with rd1=3, regwrite1=1; lane2 none -> one cycle later wb_data1=0x10, wb_rd1=3, wb_we1=1, mem_stall never high.
- Lane1 SW addr 0x40 data 0xDEAD_BEEF; lane2 LW addr 0x40 rd2=5 -> mem_stall=1 for exactly 1 cycle, DM word 0x10 written, then wb_data2=0xDEAD_BEEF, wb_we2=1, wb_we1=0.
- Lane1 LW addr 0x8 (DM holds 0x1234); lane2 LW addr 0xC (DM holds 0x5678) -> 1 stall cycle, then wb_data1=0x1234 and wb_data2=0x5678 in the same cycle.
- Lane1 SW and lane2 SW with clear_lane2=1 -> no stall, only lane-1 write occurs, wb_we2=0.
- Dual-memory-op bundle with RST asserted in S_SECOND -> no lane-2 DM write, all wb_* = 0 next cycle, state S_RUN.
- With ALIGN_CHECK_EN: SW addr 0x41 -> dm_we stays 0, misalign1=1 one cycle later.
